// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the memory stage and the data-memory unit.
// The access-size field is named acc_type because type is a reserved word.
interface data_memory_unit_if;
   logic        sig_load;
   logic        sig_store;
   logic [2:0]  acc_type;
   logic [31:0] addr;
   logic [31:0] data;
   logic [31:0] q;
   logic        q_valid;
   logic        mem_stall;
   logic        misalign;
   logic        addr_fault;

   modport master (
      output sig_load, sig_store, acc_type, addr, data,
      input  q, q_valid, mem_stall, misalign, addr_fault
   );

   modport slave (
      input  sig_load, sig_store, acc_type, addr, data,
      output q, q_valid, mem_stall, misalign, addr_fault
   );
endinterface

// File: rtl/data_memory_unit.sv
// Load/store unit in front of a synchronous single-port word RAM: sub-word loads
// with extension, sub-word stores via byte enables or a two-cycle read-modify-write.
module data_memory_unit #(
   parameter int unsigned WORD_ADDR_W    = 12,
   parameter bit          BYTE_ENABLE    = 1'b0,
   parameter bit          MISALIGN_CHECK = 1'b1
) (
   input  logic             cpu_clk,
   input  logic             rst_n,
   data_memory_unit_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StMerge} state_e;

   function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] ln);
      case (sz)
         2'b00:   return 4'b0001 << ln;
         2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] ln, input logic zext);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*ln +: 8];
      h = ln[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   return zext ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   return zext ? {16'd0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   state_e                 state_q, state_d;
   logic                   q_valid_q, q_valid_d;
   logic                   misalign_q, misalign_d;
   logic                   addr_fault_q, addr_fault_d;
   logic [1:0]             cap_lane_q, cap_lane_d;
   logic [1:0]             cap_size_q, cap_size_d;
   logic                   cap_zext_q, cap_zext_d;
   logic [31:0]            cap_data_q, cap_data_d;
   logic [WORD_ADDR_W-1:0] cap_idx_q, cap_idx_d;

   logic [31:0]            mem [2**WORD_ADDR_W];
   logic [31:0]            rdata_q;

   logic                   ram_re, ram_we;
   logic [WORD_ADDR_W-1:0] ram_idx;
   logic [31:0]            ram_wdata;
   logic [3:0]             ram_be;

   logic                   req, fault_addr, fault_mis, ok, store_ok, load_ok, rmw_start;
   logic [1:0]             size, lane;
   logic [WORD_ADDR_W-1:0] idx;

   assign req        = bus.sig_load | bus.sig_store;
   assign size       = bus.acc_type[1:0];
   assign lane       = bus.addr[1:0];
   assign idx        = bus.addr[WORD_ADDR_W+1:2];
   assign fault_addr = (bus.addr >> (WORD_ADDR_W + 2)) != 32'd0;
   assign fault_mis  = MISALIGN_CHECK &&
                       (((size == 2'b01) && bus.addr[0]) || (size[1] && (bus.addr[1:0] != 2'b00)));
   assign ok         = req && !fault_addr && !fault_mis;
   // A simultaneous load and store is handled as a store.
   assign store_ok   = ok && bus.sig_store;
   assign load_ok    = ok && bus.sig_load && !bus.sig_store;
   assign rmw_start  = (state_q == StIdle) && store_ok && !BYTE_ENABLE && !size[1];

   assign bus.mem_stall  = rmw_start;
   assign bus.q_valid    = q_valid_q;
   assign bus.misalign   = misalign_q;
   assign bus.addr_fault = addr_fault_q;
   assign bus.q          = q_valid_q ? extend(rdata_q, cap_size_q, cap_lane_q, cap_zext_q) : 32'd0;

   always_comb begin
      state_d      = state_q;
      q_valid_d    = 1'b0;
      misalign_d   = 1'b0;
      addr_fault_d = 1'b0;
      cap_lane_d   = cap_lane_q;
      cap_size_d   = cap_size_q;
      cap_zext_d   = cap_zext_q;
      cap_data_d   = cap_data_q;
      cap_idx_d    = cap_idx_q;
      ram_re       = 1'b0;
      ram_we       = 1'b0;
      ram_idx      = idx;
      ram_wdata    = lane_rep(size, bus.data);
      ram_be       = lane_be(size, lane);

      if (state_q == StMerge) begin
         // rdata_q holds the old word read in the stall cycle.
         ram_we    = 1'b1;
         ram_idx   = cap_idx_q;
         ram_be    = 4'b1111;
         ram_wdata = (rdata_q & ~be_mask(lane_be(cap_size_q, cap_lane_q))) |
                     (lane_rep(cap_size_q, cap_data_q) & be_mask(lane_be(cap_size_q, cap_lane_q)));
         state_d   = StIdle;
      end else if (req) begin
         addr_fault_d = fault_addr;
         misalign_d   = !fault_addr && fault_mis;
         if (rmw_start) begin
            ram_re     = 1'b1;
            cap_idx_d  = idx;
            cap_lane_d = lane;
            cap_size_d = size;
            cap_data_d = bus.data;
            state_d    = StMerge;
         end else if (store_ok) begin
            ram_we = 1'b1;
         end else if (load_ok) begin
            ram_re     = 1'b1;
            q_valid_d  = 1'b1;
            cap_lane_d = lane;
            cap_size_d = size;
            cap_zext_d = bus.acc_type[2];
         end
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         q_valid_q    <= 1'b0;
         misalign_q   <= 1'b0;
         addr_fault_q <= 1'b0;
         cap_lane_q   <= 2'd0;
         cap_size_q   <= 2'd0;
         cap_zext_q   <= 1'b0;
         cap_data_q   <= 32'd0;
         cap_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         q_valid_q    <= q_valid_d;
         misalign_q   <= misalign_d;
         addr_fault_q <= addr_fault_d;
         cap_lane_q   <= cap_lane_d;
         cap_size_q   <= cap_size_d;
         cap_zext_q   <= cap_zext_d;
         cap_data_q   <= cap_data_d;
         cap_idx_q    <= cap_idx_d;
      end
   end

   // Contents are not reset; reset only blocks the port so an in-flight merge is dropped.
   always_ff @(posedge cpu_clk) begin
      if (rst_n) begin
         if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
               if (ram_be[i]) mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
         end
         if (ram_re) rdata_q <= mem[ram_idx];
      end
   end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench: one read-modify-write instance and one byte-enable instance,
// driven with hand-computed vectors.
module tb_data_memory_unit;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   data_memory_unit_if bus_rmw ();
   data_memory_unit_if bus_be ();

   data_memory_unit #(
      .WORD_ADDR_W   (12),
      .BYTE_ENABLE   (1'b0),
      .MISALIGN_CHECK(1'b1)
   ) u_dut_rmw (
      .cpu_clk(clk),
      .rst_n  (rst_n),
      .bus    (bus_rmw)
   );

   data_memory_unit #(
      .WORD_ADDR_W   (12),
      .BYTE_ENABLE   (1'b1),
      .MISALIGN_CHECK(1'b1)
   ) u_dut_be (
      .cpu_clk(clk),
      .rst_n  (rst_n),
      .bus    (bus_be)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic ld, input logic st, input logic [2:0] ty,
                        input logic [31:0] ad, input logic [31:0] da);
      if (d == 0) begin
         bus_rmw.sig_load = ld; bus_rmw.sig_store = st; bus_rmw.acc_type = ty;
         bus_rmw.addr = ad;     bus_rmw.data = da;
      end else begin
         bus_be.sig_load = ld;  bus_be.sig_store = st;  bus_be.acc_type = ty;
         bus_be.addr = ad;      bus_be.data = da;
      end
   endtask

   task automatic idle(input int d);
      drive(d, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
   endtask

   task automatic check_out(input int d, input string tag, input logic [31:0] eq,
                            input logic eqv, input logic emis, input logic eaf);
      if (d == 0) begin
         check_eq({tag, ".q"}, bus_rmw.q, eq);
         check_eq({tag, ".q_valid"}, {31'd0, bus_rmw.q_valid}, {31'd0, eqv});
         check_eq({tag, ".misalign"}, {31'd0, bus_rmw.misalign}, {31'd0, emis});
         check_eq({tag, ".addr_fault"}, {31'd0, bus_rmw.addr_fault}, {31'd0, eaf});
      end else begin
         check_eq({tag, ".q"}, bus_be.q, eq);
         check_eq({tag, ".q_valid"}, {31'd0, bus_be.q_valid}, {31'd0, eqv});
         check_eq({tag, ".misalign"}, {31'd0, bus_be.misalign}, {31'd0, emis});
         check_eq({tag, ".addr_fault"}, {31'd0, bus_be.addr_fault}, {31'd0, eaf});
      end
   endtask

   task automatic check_stall(input int d, input string tag, input logic exp);
      if (d == 0) check_eq(tag, {31'd0, bus_rmw.mem_stall}, {31'd0, exp});
      else        check_eq(tag, {31'd0, bus_be.mem_stall}, {31'd0, exp});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      idle(0);
      idle(1);
      step();
      step();
      check_out(0, "reset_rmw", 32'd0, 1'b0, 1'b0, 1'b0);
      check_out(1, "reset_be", 32'd0, 1'b0, 1'b0, 1'b0);
      check_stall(0, "reset_stall", 1'b0);
      rst_n = 1'b1;
      step();

      for (int d = 0; d < 2; d++) begin
         // Word store, then back-to-back sub-word loads.
         drive(d, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
         #1 check_stall(d, "sw_stall", 1'b0);
         step();
         drive(d, 1'b1, 1'b0, 3'b000, 32'h13, 32'd0);
         #1 check_out(d, "after_sw", 32'd0, 1'b0, 1'b0, 1'b0);
         step();
         drive(d, 1'b1, 1'b0, 3'b101, 32'h12, 32'd0);
         #1 check_out(d, "lb_13", 32'hFFFFFFDE, 1'b1, 1'b0, 1'b0);
         step();
         idle(d);
         #1 check_out(d, "lhu_12", 32'h0000DEAD, 1'b1, 1'b0, 1'b0);
         step();
         check_out(d, "load_pulse_end", 32'd0, 1'b0, 1'b0, 1'b0);

         // Byte store over the word, then immediate word load.
         drive(d, 1'b0, 1'b1, 3'b000, 32'h11, 32'h0000005A);
         #1 check_stall(d, "sb_stall_first", (d == 0));
         if (d == 0) begin
            step();
            #1 check_stall(d, "sb_stall_merge", 1'b0);
            check_out(d, "merge_outputs", 32'd0, 1'b0, 1'b0, 1'b0);
         end
         step();
         drive(d, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
         #1 check_stall(d, "lw_stall", 1'b0);
         step();
         idle(d);
         #1 check_out(d, "lw_merged", 32'hDEAD5AEF, 1'b1, 1'b0, 1'b0);
         step();
      end

      // Misaligned half load and word store leave memory untouched.
      drive(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
      step();
      drive(0, 1'b1, 1'b0, 3'b001, 32'h21, 32'd0);
      #1 check_stall(0, "mis_lh_stall", 1'b0);
      step();
      drive(0, 1'b0, 1'b1, 3'b010, 32'h22, 32'h12345678);
      #1 check_out(0, "mis_lh", 32'd0, 1'b0, 1'b1, 1'b0);
      check_stall(0, "mis_sw_stall", 1'b0);
      step();
      idle(0);
      #1 check_out(0, "mis_sw", 32'd0, 1'b0, 1'b1, 1'b0);
      step();
      check_out(0, "mis_clear", 32'd0, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
      step();
      idle(0);
      #1 check_out(0, "mis_unchanged", 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
      step();

      // Out-of-range addresses fault ahead of misalignment, without stalling.
      drive(0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h11223344);
      step();
      drive(0, 1'b0, 1'b1, 3'b010, 32'h00004000, 32'hFFFFFFFF);
      #1 check_stall(0, "af_sw_stall", 1'b0);
      step();
      drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
      #1 check_out(0, "af_sw", 32'd0, 1'b0, 1'b0, 1'b1);
      step();
      drive(0, 1'b1, 1'b0, 3'b010, 32'h00004002, 32'd0);
      #1 check_out(0, "af_word0", 32'h11223344, 1'b1, 1'b0, 1'b0);
      step();
      drive(0, 1'b0, 1'b1, 3'b000, 32'h00004001, 32'h000000AA);
      #1 check_out(0, "af_priority", 32'd0, 1'b0, 1'b0, 1'b1);
      check_stall(0, "af_sb_no_stall", 1'b0);
      step();
      idle(0);
      #1 check_out(0, "af_sb", 32'd0, 1'b0, 1'b0, 1'b1);
      step();

      // Reset in the merge cycle drops the write and returns to idle.
      drive(0, 1'b0, 1'b1, 3'b010, 32'h30, 32'hA5A5A5A5);
      step();
      drive(0, 1'b0, 1'b1, 3'b000, 32'h31, 32'h000000FF);
      #1 check_stall(0, "rst_sb_stall", 1'b1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      idle(0);
      #1 check_out(0, "rst_outputs", 32'd0, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
      #1 check_stall(0, "rst_lw_stall", 1'b0);
      step();
      drive(0, 1'b0, 1'b1, 3'b000, 32'h31, 32'h00000077);
      #1 check_out(0, "rst_kept_old", 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
      check_stall(0, "post_rst_sb_stall", 1'b1);
      step();
      #1 check_stall(0, "post_rst_sb_merge", 1'b0);
      step();
      drive(0, 1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
      step();
      idle(0);
      #1 check_out(0, "post_rst_merged", 32'hA5A577A5, 1'b1, 1'b0, 1'b0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Parametrised data-memory load/store unit for the RISC-V core.
- Sits between the execute/memory stage and an internal synchronous single-port word RAM.
- Handles byte, half and word loads with sign or zero extension.
- Sub-word stores use either RAM byte enables (single cycle) or a read-modify-write sequence with a real stall.
- Flags misaligned and out-of-range accesses.

Parameters:
- WORD_ADDR_W, 12, word-address bits; RAM holds 2^WORD_ADDR_W 32-bit words.
- BYTE_ENABLE, 0, 1 = RAM has per-byte write enables and every store completes in one cycle; 0 = sub-word stores use a 2-cycle read-modify-write.
- MISALIGN_CHECK, 1, 1 = detect misaligned half/word accesses and suppress them; 0 = ignore addr low bits for word (addr[1:0]) and half (addr[0]).

Ports:
- cpu_clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- sig_load  input  1  load request; held stable by the CPU while mem_stall=1.
- sig_store  input  1  store request; held stable by the CPU while mem_stall=1.
- type  input  3  [1:0] size: 00 byte, 01 half, 10 word, 11 treated as word; [2]=1 zero-extend, 0 sign-extend (loads only).
- addr  input  32  byte address.
- data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- q  output  32  extended load data; 0 whenever q_valid=0.
- q_valid  output  1  one-cycle pulse, cycle after an accepted load.
- mem_stall  output  1  combinational; 1 = request not accepted this cycle.
- misalign  output  1  one-cycle pulse, cycle after a rejected misaligned request.
- addr_fault  output  1  one-cycle pulse, cycle after a request with addr[31:WORD_ADDR_W+2] != 0.

Behaviour:
- Reset (rst_n=0 at edge):
  - FSM -> IDLE; q, q_valid, misalign and addr_fault -> 0; captured store data cleared.
  - RAM contents are not reset.
  - Reset during MERGE aborts the write; memory is unchanged.
- Acceptance: a request is accepted on an edge where (sig_load|sig_store)=1 and mem_stall=0.
- Simultaneous sig_load and sig_store: treated as a store; no q_valid.
- Word index: addr[WORD_ADDR_W+1:2].
- Fault priority:
  - addr_fault beats misalign. A faulting request is accepted with no RAM access and no stall; the corresponding flag pulses next cycle.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0 (only when MISALIGN_CHECK=1).
  - A faulted load gives q_valid=0.
- Load:
  - RAM read on the accept edge.
  - Next cycle q_valid=1 and q carries the selected lane, extended per type[2].
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Latency 1, no stall, back-to-back loads every cycle.
- Store, word or BYTE_ENABLE=1:
  - Written on the accept edge using byte enables derived from size and addr[1:0].
  - No stall.
- Store, sub-word with BYTE_ENABLE=0 (FSM IDLE -> MERGE -> IDLE):
  - IDLE cycle: mem_stall=1, RAM read of the target word; data and addr low bits captured; FSM -> MERGE.
  - MERGE cycle: mem_stall=0; RAM written with the old word and the captured lane replaced by the captured data; request accepted; FSM -> IDLE.
  - Throughput: one sub-word store per 2 cycles.
  - A load in the cycle after MERGE returns the merged word (write-then-read on the same word must be coherent).
- No request: RAM not enabled; outputs q, q_valid, misalign and addr_fault are 0 in the next cycle.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load signed byte at 0x13 -> q=0xFFFFFFDE, q_valid=1 exactly one cycle; unsigned half at 0x12 -> q=0x0000DEAD.
- BYTE_ENABLE=0: store byte 0x5A to 0x11 over the word above -> mem_stall=1 for 1 cycle; a load word to 0x10 in the next cycle returns 0xDEAD5AEF.
- BYTE_ENABLE=1: the same byte store -> mem_stall never asserted; the load returns 0xDEAD5AEF.
- Load half at 0x21, then store word at 0x22 -> misalign pulses once per request; RAM unchanged; q_valid=0.
- With WORD_ADDR_W=12, store word to 0x00004000 -> addr_fault pulses; a load of word 0 still returns its prior value.
- rst_n=0 asserted during the MERGE cycle of a byte store -> the target word keeps its old value; all outputs 0 the following cycle; FSM in IDLE (next request accepted without extra stall).
